// File: rtl/usertype.sv
// Shared types for the DRAM command scheduler: command word, DRAM op codes, per-bank state, FSM states.
// The optional refresh states exist only when SCHED_REFRESH_EN is defined.
package usertype;

    localparam int NUM_BANKS = 8;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ACT  = 3'd1,
        OP_RD   = 3'd2,
        OP_WR   = 3'd3,
        OP_PRE  = 3'd4,
        OP_PREA = 3'd5,
        OP_REF  = 3'd6
    } dram_op_t;

    // Upper three bits are reserved; the rest packs into bits [28:0].
    typedef struct packed {
        logic [2:0]  rsvd;
        logic        r_w;
        logic [12:0] row_addr;
        logic        burst_length;
        logic        auto_precharge;
        logic [9:0]  col_addr;
        logic [2:0]  bank_addr;
    } command_t;

    typedef struct packed {
        logic        open;
        logic [12:0] row;
    } bank_state_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_RP,
        S_ACT,
        S_WAIT_RCD,
        S_CAS
`ifdef SCHED_REFRESH_EN
        ,
        S_PREA,
        S_WAIT_RPA,
        S_REF,
        S_WAIT_RFC
`endif
    } sched_state_t;

endpackage

// File: rtl/dram_cmd_scheduler_if.sv
// Host command handshake plus DRAM PHY command bus of the scheduler.
interface dram_cmd_scheduler_if;
    import usertype::*;

    logic        cmd_valid;
    logic        cmd_ready;
    command_t    cmd_in;
    dram_op_t    dram_op;
    logic [2:0]  dram_bank;
    logic [12:0] dram_addr;
    logic        dram_ap;
    logic        dram_bl;
    logic        busy;

    modport master (
        output cmd_valid, cmd_in,
        input  cmd_ready, dram_op, dram_bank, dram_addr, dram_ap, dram_bl, busy
    );

    modport slave (
        input  cmd_valid, cmd_in,
        output cmd_ready, dram_op, dram_bank, dram_addr, dram_ap, dram_bl, busy
    );
endinterface

// File: rtl/bank_tracker.sv
// Per-bank open flag, open row and precharge (tRP) down-counter, with a combinational
// hit/closed/conflict lookup and single-bank activate/close plus all-bank flush updates.
module bank_tracker
    import usertype::*;
#(
    parameter int T_RP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  lk_bank,
    input  logic [12:0] lk_row,
    output logic        lk_hit,
    output logic        lk_closed,
    output logic        lk_conflict,
    output logic        lk_rp_zero,
    output logic        lk_rp_last,
    input  logic [2:0]  upd_bank,
    input  logic [12:0] upd_row,
    input  logic        act_en,
    input  logic        close_en,
    input  logic        flush_en,
    output logic        any_open
);

    localparam int RP_W = (T_RP > 1) ? $clog2(T_RP) : 1;

    bank_state_t     bank_q [NUM_BANKS];
    bank_state_t     bank_d [NUM_BANKS];
    logic [RP_W-1:0] rp_q   [NUM_BANKS];
    logic [RP_W-1:0] rp_d   [NUM_BANKS];

    // NOTE: every always_comb output gets its default first, so no path leaves it unassigned (no latch).
    always_comb begin
        any_open = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_d[b] = bank_q[b];
            rp_d[b]   = (rp_q[b] != '0) ? rp_q[b] - RP_W'(1) : '0;
            if (flush_en) begin
                bank_d[b].open = 1'b0;
                rp_d[b]        = '0;
            end else if (upd_bank == 3'(b)) begin
                if (act_en) begin
                    bank_d[b].open = 1'b1;
                    bank_d[b].row  = upd_row;
                end
                if (close_en) begin
                    bank_d[b].open = 1'b0;
                    rp_d[b]        = RP_W'(T_RP - 1);
                end
            end
            any_open = any_open | bank_q[b].open;
        end
    end

    // NOTE: this small array is reset explicitly; a stale open flag after reset would skip a required ACT.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_q[b] <= '0;
                rp_q[b]   <= '0;
            end
        end else begin
            bank_q <= bank_d;
            rp_q   <= rp_d;
        end
    end

    assign lk_closed   = !bank_q[lk_bank].open;
    assign lk_hit      = bank_q[lk_bank].open && (bank_q[lk_bank].row == lk_row);
    assign lk_conflict = bank_q[lk_bank].open && (bank_q[lk_bank].row != lk_row);
    assign lk_rp_zero  = (rp_q[lk_bank] == '0);
    assign lk_rp_last  = (rp_q[lk_bank] <= RP_W'(1));

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Single-command DRAM scheduler: turns one host command into the minimal PRE/ACT/RD/WR sequence.
// Define SCHED_REFRESH_EN to add periodic PREA/REF refresh; all outputs are registered.
module dram_cmd_scheduler
    import usertype::*;
#(
    parameter int T_RCD  = 4,
    parameter int T_RP   = 4,
    parameter int T_REFI = 1560,
    parameter int T_RFC  = 52
) (
    input logic                 clk,
    input logic                 rst,
    dram_cmd_scheduler_if.slave bus
);

    sched_state_t state_q, state_d;
    command_t     cmd_q, cmd_d;
    logic [15:0]  wait_q, wait_d;
    dram_op_t     op_q, op_d;
    logic [2:0]   bank_q, bank_d;
    logic [12:0]  addr_q, addr_d;
    logic         ap_q, ap_d, bl_q, bl_d, busy_q, busy_d, cmd_ready_q, cmd_ready_d;
    logic         accept, idle_next, flush_en, any_open;
    logic         lk_hit, lk_closed, lk_conflict, lk_rp_zero, lk_rp_last;
    logic [2:0]   lk_bank;
    logic [12:0]  lk_row;
    logic         unused_rsvd;

    assign accept      = bus.cmd_valid && cmd_ready_q;
    assign lk_bank     = (state_q == S_IDLE) ? bus.cmd_in.bank_addr : cmd_q.bank_addr;
    assign lk_row      = (state_q == S_IDLE) ? bus.cmd_in.row_addr  : cmd_q.row_addr;
    assign unused_rsvd = ^cmd_q.rsvd;

`ifdef SCHED_REFRESH_EN
    logic [15:0] refi_q, refi_d;
    logic        ref_pend_q, ref_pend_d, ref_done;

    assign flush_en = (state_q == S_PREA) || (state_q == S_REF);
    assign ref_done = ((state_q == S_REF) || (state_q == S_WAIT_RFC)) && (state_d == S_IDLE);

    // Expiries seen while a refresh is already running are absorbed by that refresh.
    always_comb begin
        refi_d     = (refi_q == '0) ? 16'(T_REFI - 1) : refi_q - 16'd1;
        ref_pend_d = ref_pend_q || (refi_q == '0);
        if (ref_done) ref_pend_d = 1'b0;
    end
`else
    localparam int unused_refresh_cfg = T_REFI + T_RFC;
    logic unused_any_open;
    assign unused_any_open = any_open;
    assign flush_en        = 1'b0;
`endif

    bank_tracker #(.T_RP(T_RP)) u_banks (
        .clk        (clk),
        .rst        (rst),
        .lk_bank    (lk_bank),
        .lk_row     (lk_row),
        .lk_hit     (lk_hit),
        .lk_closed  (lk_closed),
        .lk_conflict(lk_conflict),
        .lk_rp_zero (lk_rp_zero),
        .lk_rp_last (lk_rp_last),
        .upd_bank   (cmd_q.bank_addr),
        .upd_row    (cmd_q.row_addr),
        .act_en     (state_q == S_ACT),
        .close_en   ((state_q == S_PRE) || ((state_q == S_CAS) && cmd_q.auto_precharge)),
        .flush_en   (flush_en),
        .any_open   (any_open)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cmd_d = bus.cmd_in;
                    if (lk_hit)                       state_d = S_CAS;
                    else if (lk_closed && lk_rp_zero) state_d = S_ACT;
                    else if (lk_closed)               state_d = S_WAIT_RP;
                    else if (lk_conflict)             state_d = S_PRE;
                end
`ifdef SCHED_REFRESH_EN
                else if (ref_pend_q) begin
                    state_d = any_open ? S_PREA : S_REF;
                end
`endif
            end
            S_PRE:     state_d = (T_RP == 1) ? S_ACT : S_WAIT_RP;
            // Leave one cycle early: the counter reaches zero as the ACT state is entered.
            S_WAIT_RP: if (lk_rp_last) state_d = S_ACT;
            S_ACT: begin
                if (T_RCD == 1) begin
                    state_d = S_CAS;
                end else begin
                    state_d = S_WAIT_RCD;
                    wait_d  = 16'(T_RCD - 2);
                end
            end
            S_WAIT_RCD: begin
                if (wait_q == '0) state_d = S_CAS;
                else              wait_d  = wait_q - 16'd1;
            end
            S_CAS: state_d = S_IDLE;
`ifdef SCHED_REFRESH_EN
            S_PREA: begin
                if (T_RP == 1) begin
                    state_d = S_REF;
                end else begin
                    state_d = S_WAIT_RPA;
                    wait_d  = 16'(T_RP - 2);
                end
            end
            S_WAIT_RPA: begin
                if (wait_q == '0) state_d = S_REF;
                else              wait_d  = wait_q - 16'd1;
            end
            S_REF: begin
                if (T_RFC == 1) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_RFC;
                    wait_d  = 16'(T_RFC - 2);
                end
            end
            S_WAIT_RFC: begin
                if (wait_q == '0) state_d = S_IDLE;
                else              wait_d  = wait_q - 16'd1;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are a registered image of the current state, so each op appears one cycle after its state.
    always_comb begin
        op_d   = OP_NOP;
        bank_d = '0;
        addr_d = '0;
        ap_d   = 1'b0;
        bl_d   = 1'b0;
        case (state_q)
            S_ACT: begin
                op_d   = OP_ACT;
                bank_d = cmd_q.bank_addr;
                addr_d = cmd_q.row_addr;
            end
            S_PRE: begin
                op_d   = OP_PRE;
                bank_d = cmd_q.bank_addr;
            end
            S_CAS: begin
                op_d   = cmd_q.r_w ? OP_WR : OP_RD;
                bank_d = cmd_q.bank_addr;
                addr_d = {3'b000, cmd_q.col_addr};
                ap_d   = cmd_q.auto_precharge;
                bl_d   = cmd_q.burst_length;
            end
`ifdef SCHED_REFRESH_EN
            S_PREA:  op_d = OP_PREA;
            S_REF:   op_d = OP_REF;
`endif
            default: op_d = OP_NOP;
        endcase
        idle_next   = (state_q == S_IDLE) && (state_d == S_IDLE);
        busy_d      = !idle_next;
`ifdef SCHED_REFRESH_EN
        cmd_ready_d = idle_next && !ref_pend_d;
`else
        cmd_ready_d = idle_next;
`endif
    end

    // NOTE: registers take only non-blocking assignments; all next-value logic stays in always_comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            wait_q      <= '0;
            op_q        <= OP_NOP;
            bank_q      <= '0;
            addr_q      <= '0;
            ap_q        <= 1'b0;
            bl_q        <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
`ifdef SCHED_REFRESH_EN
            refi_q      <= 16'(T_REFI - 1);
            ref_pend_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            wait_q      <= wait_d;
            op_q        <= op_d;
            bank_q      <= bank_d;
            addr_q      <= addr_d;
            ap_q        <= ap_d;
            bl_q        <= bl_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
`ifdef SCHED_REFRESH_EN
            refi_q      <= refi_d;
            ref_pend_q  <= ref_pend_d;
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.dram_op   = op_q;
    assign bus.dram_bank = bank_q;
    assign bus.dram_addr = addr_q;
    assign bus.dram_ap   = ap_q;
    assign bus.dram_bl   = bl_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed bench for dram_cmd_scheduler (T_RCD=4, T_RP=4); the refresh scenario is built only
// when SCHED_REFRESH_EN is defined. Inputs change and outputs are sampled on the falling edge.
module tb_dram_cmd_scheduler;
    import usertype::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dram_cmd_scheduler_if bus ();
    dram_cmd_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef SCHED_REFRESH_EN
    dram_cmd_scheduler_if bus2 ();
    dram_cmd_scheduler #(.T_REFI(20)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic command_t mk(input logic rw, input logic [2:0] bank, input logic [12:0] row,
                                    input logic [9:0] col, input logic ap, input logic bl);
        command_t c;
        c                = '0;
        c.r_w            = rw;
        c.bank_addr      = bank;
        c.row_addr       = row;
        c.col_addr       = col;
        c.auto_precharge = ap;
        c.burst_length   = bl;
        return c;
    endfunction

    task automatic expect_op(input string tag, input dram_op_t op, input logic [2:0] bank,
                             input logic [12:0] addr);
        check({tag, "_op"}, bus.dram_op, op);
        check({tag, "_bank"}, bus.dram_bank, bank);
        check({tag, "_addr"}, bus.dram_addr, addr);
    endtask

    // Returns in the cycle right after the acceptance edge.
    task automatic issue(input command_t c);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check("ready_before_issue", bus.cmd_ready, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_in    = c;
        step(1);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_in    = '0;
`ifdef SCHED_REFRESH_EN
        bus2.cmd_valid = 1'b0;
        bus2.cmd_in    = '0;
`endif
        step(3);
        check("rst_op", bus.dram_op, OP_NOP);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_ready", bus.cmd_ready, 1'b0);
        check("rst_addr", bus.dram_addr, 13'h0);
        rst = 1'b0;
        step(1);
        check("ready_after_rst", bus.cmd_ready, 1'b1);

        // Closed bank: ACT at T+1, RD at T+5, ready again at T+6.
        issue(mk(1'b0, 3'd2, 13'h0100, 10'h010, 1'b0, 1'b1));
        check("t1_busy", bus.busy, 1'b1);
        check("t1_ready_low", bus.cmd_ready, 1'b0);
        step(1); expect_op("t1_act", OP_ACT, 3'd2, 13'h0100);
        step(2); check("t1_rcd_nop", bus.dram_op, OP_NOP);
        step(2); expect_op("t1_rd", OP_RD, 3'd2, 13'h0010);
        check("t1_bl", bus.dram_bl, 1'b1);
        check("t1_ap", bus.dram_ap, 1'b0);
        check("t1_ready_still_low", bus.cmd_ready, 1'b0);
        step(1);
        check("t1_ready_back", bus.cmd_ready, 1'b1);
        check("t1_busy_clear", bus.busy, 1'b0);

        // Row hit: RD directly at T+1.
        issue(mk(1'b0, 3'd2, 13'h0100, 10'h020, 1'b0, 1'b0));
        step(1); expect_op("t2_hit_rd", OP_RD, 3'd2, 13'h0020);
        step(1); check("t2_ready_back", bus.cmd_ready, 1'b1);

        // Row conflict write: PRE at T+1, ACT at T+5, WR at T+9.
        issue(mk(1'b1, 3'd2, 13'h0200, 10'h005, 1'b0, 1'b0));
        step(1); expect_op("t3_pre", OP_PRE, 3'd2, 13'h0000);
        step(4); expect_op("t3_act", OP_ACT, 3'd2, 13'h0200);
        step(4); expect_op("t3_wr", OP_WR, 3'd2, 13'h0005);
        step(1); check("t3_ready_back", bus.cmd_ready, 1'b1);

        // Auto-precharge read, then same row again: ACT waits out tRP from the RD.
        issue(mk(1'b0, 3'd5, 13'h00AB, 10'h3FF, 1'b1, 1'b0));
        step(5); expect_op("t4_rd_ap", OP_RD, 3'd5, 13'h03FF);
        check("t4_ap_set", bus.dram_ap, 1'b1);
        step(1);
        issue(mk(1'b0, 3'd5, 13'h00AB, 10'h011, 1'b0, 1'b0));
        step(1); check("t4_no_early_op", bus.dram_op, OP_NOP);
        step(1); expect_op("t4_act_after_rp", OP_ACT, 3'd5, 13'h00AB);
        step(4); expect_op("t4_rd", OP_RD, 3'd5, 13'h0011);
        check("t4_ap_clear", bus.dram_ap, 1'b0);
        step(1);

        // Bank 2 still holds row 0x200 despite the bank 5 traffic.
        issue(mk(1'b0, 3'd2, 13'h0200, 10'h077, 1'b0, 1'b0));
        step(1); expect_op("t5_other_bank_hit", OP_RD, 3'd2, 13'h0077);
        step(1);

        // Reset during WAIT_RCD aborts; banks come back closed.
        issue(mk(1'b0, 3'd3, 13'h0010, 10'h001, 1'b0, 1'b0));
        step(2); check("t6_busy_in_rcd", bus.busy, 1'b1);
        rst = 1'b1;
        step(1);
        check("t6_rst_op", bus.dram_op, OP_NOP);
        check("t6_rst_busy", bus.busy, 1'b0);
        check("t6_rst_ready", bus.cmd_ready, 1'b0);
        rst = 1'b0;
        step(1); check("t6_ready_after_rst", bus.cmd_ready, 1'b1);
        step(1); check("t6_no_cas", bus.dram_op, OP_NOP);
        issue(mk(1'b0, 3'd3, 13'h0010, 10'h001, 1'b0, 1'b0));
        step(1); expect_op("t6_act_after_rst", OP_ACT, 3'd3, 13'h0010);
        step(4); expect_op("t6_rd", OP_RD, 3'd3, 13'h0001);
        step(1);
        issue(mk(1'b0, 3'd2, 13'h0200, 10'h002, 1'b0, 1'b0));
        step(1); expect_op("t6_bank2_closed", OP_ACT, 3'd2, 13'h0200);
        step(6);

`ifdef SCHED_REFRESH_EN
        begin
            int n;
            rst = 1'b1;
            step(2);
            rst = 1'b0;
            step(1);
            bus2.cmd_valid = 1'b1;
            bus2.cmd_in    = mk(1'b0, 3'd1, 13'h0001, 10'h004, 1'b0, 1'b0);
            step(1);
            bus2.cmd_valid = 1'b0;
            step(1); check("r_act_open", bus2.dram_op, OP_ACT);
            n = 0;
            while (bus2.dram_op !== OP_PREA && n < 60) begin
                step(1);
                n++;
            end
            check("r_prea_seen", bus2.dram_op, OP_PREA);
            check("r_ready_low_prea", bus2.cmd_ready, 1'b0);
            n = 0;
            do begin
                step(1);
                n++;
            end while (bus2.dram_op === OP_NOP && n < 10);
            check("r_ref_op", bus2.dram_op, OP_REF);
            check("r_prea_to_ref", n, 4);
            step(51); check("r_ready_low_rfc", bus2.cmd_ready, 1'b0);
            step(1);  check("r_ready_after_rfc", bus2.cmd_ready, 1'b1);
            bus2.cmd_valid = 1'b1;
            bus2.cmd_in    = mk(1'b0, 3'd1, 13'h0001, 10'h008, 1'b0, 1'b0);
            step(1);
            bus2.cmd_valid = 1'b0;
            step(1);
            check("r_act_after_ref", bus2.dram_op, OP_ACT);
            check("r_act_row", bus2.dram_addr, 13'h0001);
            step(2);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
